// File: rtl/cache_def.sv
// Shared cache definitions: CPU<->cache request/result types plus the order
// risk checker's state, reason-code and client-word field definitions.
package cache_def;

  // CPU request to the cache controller.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;     // 0 = read, 1 = write
    logic        valid;
  } cpu_req_type;

  // Cache controller result back to the CPU side.
  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  // Order risk checker control states.
  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StCheck,
    StWrReq,
    StResp
  } checker_state_type;

  // Result reason codes; RsnRsvd is never driven.
  typedef enum logic [1:0] {
    RsnOk      = 2'b00,
    RsnLimit   = 2'b01,
    RsnTimeout = 2'b10,
    RsnRsvd    = 2'b11
  } reason_type;

  // Per-client cache word: [31:16] max-to-trade, [15:0] accumulated quantity.
  localparam int MAX_MSB = 31;
  localparam int MAX_LSB = 16;
  localparam int ACC_MSB = 15;

endpackage

// File: rtl/order_risk_checker.sv
// Order risk checker. Accepts one order or limit-update command at a time,
// reads the client's word from the cache, checks/updates the accumulated
// quantity against the client's limit, writes the word back when it changes
// and returns an accept/reject result.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   order_*                    order/command handshake and fields
//   cpu_req / cpu_res          request to / result from dm_cache_fsm_upstream
//   result_*                   result handshake and fields
//   accept_count/reject_count  wrapping event counters (updated at result handshake)
module order_risk_checker
  import cache_def::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           order_valid,
  output logic           order_ready,
  input  logic [9:0]     order_client_id,
  input  logic [15:0]    order_qty,
  input  logic           order_set_limit,
  input  logic [15:0]    order_limit,
  output cpu_req_type    cpu_req,
  input  cpu_result_type cpu_res,
  output logic           result_valid,
  input  logic           result_ready,
  output logic           result_accept,
  output logic [1:0]     result_reason,
  output logic [9:0]     result_client_id,
  output logic [15:0]    accept_count,
  output logic [15:0]    reject_count
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  checker_state_type state_q, state_d;
  logic [9:0]      client_q, client_d;
  logic [15:0]     qty_q, qty_d;
  logic            set_limit_q, set_limit_d;
  logic [15:0]     limit_q, limit_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            accept_q, accept_d;
  reason_type      reason_q, reason_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [15:0]     acc_cnt_q, acc_cnt_d;
  logic [15:0]     rej_cnt_q, rej_cnt_d;

  logic [15:0]     cur_max;
  logic [15:0]     cur_acc;
  logic [16:0]     sum;
  logic [TmoW-1:0] tmo_inc;
  logic            tmo_hit;

  assign cur_max = rdata_q[MAX_MSB:MAX_LSB];
  assign cur_acc = rdata_q[ACC_MSB:0];
  // Carry bit kept so an overflowing sum can never pass the limit compare.
  assign sum     = {1'b0, cur_acc} + {1'b0, qty_q};
  assign tmo_inc = tmo_q + TmoW'(1);
  assign tmo_hit = (tmo_inc == TmoW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d      = state_q;
    client_d     = client_q;
    qty_d        = qty_q;
    set_limit_d  = set_limit_q;
    limit_d      = limit_q;
    rdata_d      = rdata_q;
    wdata_d      = wdata_q;
    accept_d     = accept_q;
    reason_d     = reason_q;
    tmo_d        = tmo_q;
    acc_cnt_d    = acc_cnt_q;
    rej_cnt_d    = rej_cnt_q;
    order_ready  = 1'b0;
    result_valid = 1'b0;
    // Address/data come straight from registers, so they stay stable while valid.
    cpu_req       = '0;
    cpu_req.addr  = {18'b0, client_q, 4'b0000};
    cpu_req.data  = wdata_q;

    unique case (state_q)
      StIdle: begin
        order_ready = 1'b1;
        if (order_valid) begin
          client_d    = order_client_id;
          qty_d       = order_qty;
          set_limit_d = order_set_limit;
          limit_d     = order_limit;
          tmo_d       = '0;
          state_d     = StRdReq;
        end
      end

      StRdReq: begin
        cpu_req.valid = 1'b1;
        if (cpu_res.ready) begin
          rdata_d = cpu_res.data;
          state_d = StCheck;
        end else if (tmo_hit) begin
          accept_d = 1'b0;
          reason_d = RsnTimeout;
          state_d  = StResp;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      StCheck: begin
        if (set_limit_q) begin
          accept_d = 1'b1;
          reason_d = RsnOk;
          wdata_d  = {limit_q, cur_acc};
          tmo_d    = '0;
          state_d  = StWrReq;
        end else if (!sum[16] && (sum[15:0] <= cur_max)) begin
          accept_d = 1'b1;
          reason_d = RsnOk;
          if (qty_q != 16'd0) begin
            wdata_d = {cur_max, sum[15:0]};
            tmo_d   = '0;
            state_d = StWrReq;
          end else begin
            // Nothing changes in the word, so skip the write.
            state_d = StResp;
          end
        end else begin
          accept_d = 1'b0;
          reason_d = RsnLimit;
          state_d  = StResp;
        end
      end

      StWrReq: begin
        cpu_req.valid = 1'b1;
        cpu_req.rw    = 1'b1;
        if (cpu_res.ready) begin
          state_d = StResp;
        end else if (tmo_hit) begin
          accept_d = 1'b0;
          reason_d = RsnTimeout;
          state_d  = StResp;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      StResp: begin
        result_valid = 1'b1;
        if (result_ready) begin
          if (accept_q) acc_cnt_d = acc_cnt_q + 16'd1;
          else          rej_cnt_d = rej_cnt_q + 16'd1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      client_q    <= '0;
      qty_q       <= '0;
      set_limit_q <= 1'b0;
      limit_q     <= '0;
      rdata_q     <= '0;
      wdata_q     <= '0;
      accept_q    <= 1'b0;
      reason_q    <= RsnOk;
      tmo_q       <= '0;
      acc_cnt_q   <= '0;
      rej_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      client_q    <= client_d;
      qty_q       <= qty_d;
      set_limit_q <= set_limit_d;
      limit_q     <= limit_d;
      rdata_q     <= rdata_d;
      wdata_q     <= wdata_d;
      accept_q    <= accept_d;
      reason_q    <= reason_d;
      tmo_q       <= tmo_d;
      acc_cnt_q   <= acc_cnt_d;
      rej_cnt_q   <= rej_cnt_d;
    end
  end

  assign result_accept    = accept_q;
  assign result_reason    = reason_q;
  assign result_client_id = client_q;
  assign accept_count     = acc_cnt_q;
  assign reject_count     = rej_cnt_q;

endmodule

// File: tb/tb_order_risk_checker.sv
// Self-checking bench for order_risk_checker: cache stub with a word array,
// a per-client limit/accumulation model, and a result scoreboard.
module tb_order_risk_checker;
  import cache_def::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           order_valid;
  logic           order_ready;
  logic [9:0]     order_client_id;
  logic [15:0]    order_qty;
  logic           order_set_limit;
  logic [15:0]    order_limit;
  cpu_req_type    cpu_req;
  cpu_result_type cpu_res;
  logic           result_valid;
  logic           result_ready;
  logic           result_accept;
  logic [1:0]     result_reason;
  logic [9:0]     result_client_id;
  logic [15:0]    accept_count;
  logic [15:0]    reject_count;

  order_risk_checker #(.TIMEOUT_CYCLES(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .order_valid      (order_valid),
    .order_ready      (order_ready),
    .order_client_id  (order_client_id),
    .order_qty        (order_qty),
    .order_set_limit  (order_set_limit),
    .order_limit      (order_limit),
    .cpu_req          (cpu_req),
    .cpu_res          (cpu_res),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result_accept    (result_accept),
    .result_reason    (result_reason),
    .result_client_id (result_client_id),
    .accept_count     (accept_count),
    .reject_count     (reject_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void check(input string name, input logic [65:0] act,
                                input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Scoreboard
  typedef struct {
    logic       acc;
    logic [1:0] rsn;
    logic [9:0] cid;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: per-client limit and accumulated quantity.
  int model_max[1024];
  int model_acc[1024];

  // Cache stub state
  logic [31:0] mem[1024];
  int          stub_lat = 0;
  logic        hang     = 1'b0;
  logic        hang_wr  = 1'b0;
  logic [9:0]  cur_cid  = '0;
  int          vcount   = 0;
  int          wr_cnt   = 0;

  initial begin
    int          wcnt;
    logic        prev_valid;
    cpu_req_type held;
    cpu_res    = '0;
    wcnt       = 0;
    prev_valid = 1'b0;
    held       = '0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        cpu_res.ready = 1'b0;
        wcnt = 0;
        prev_valid = 1'b0;
      end else if (cpu_res.ready) begin
        check("req_valid_drop_after_ready", {65'b0, cpu_req.valid}, 66'd0);
        cpu_res.ready = 1'b0;
        prev_valid = 1'b0;
        wcnt = 0;
      end else if (cpu_req.valid) begin
        vcount++;
        if (prev_valid) begin
          check("req_stable", {cpu_req.addr, cpu_req.data, cpu_req.rw},
                {held.addr, held.data, held.rw});
        end else begin
          held = cpu_req;
          check("req_addr", {34'b0, cpu_req.addr}, {52'b0, cur_cid, 4'b0000});
        end
        prev_valid = 1'b1;
        if (!hang && !(hang_wr && cpu_req.rw)) begin
          if (wcnt >= stub_lat) begin
            cpu_res.ready = 1'b1;
            if (cpu_req.rw) begin
              mem[cpu_req.addr[13:4]] = cpu_req.data;
              wr_cnt++;
            end else begin
              cpu_res.data = mem[cpu_req.addr[13:4]];
            end
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  // Monitor: result stability while stalled, scoreboard pop on handshake.
  logic [15:0] exp_acc_cnt = '0;
  logic [15:0] exp_rej_cnt = '0;
  logic        in_resp     = 1'b0;
  logic [12:0] first_res   = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_acc_cnt = '0;
      exp_rej_cnt = '0;
      in_resp     = 1'b0;
    end else if (result_valid) begin
      check("order_ready_low_in_resp", {65'b0, order_ready}, 66'd0);
      if (in_resp) begin
        check("result_stable", {53'b0, result_accept, result_reason, result_client_id},
              {53'b0, first_res});
      end else begin
        in_resp   = 1'b1;
        first_res = {result_accept, result_reason, result_client_id};
      end
      if (result_ready) begin
        in_resp = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 66'd1, 66'd0);
        end else begin
          e = exp_q.pop_front();
          check("result_accept", {65'b0, result_accept}, {65'b0, e.acc});
          check("result_reason", {64'b0, result_reason}, {64'b0, e.rsn});
          check("result_client", {56'b0, result_client_id}, {56'b0, e.cid});
          check("accept_count", {50'b0, accept_count}, {50'b0, exp_acc_cnt});
          check("reject_count", {50'b0, reject_count}, {50'b0, exp_rej_cnt});
          if (e.acc) exp_acc_cnt = exp_acc_cnt + 16'd1;
          else       exp_rej_cnt = exp_rej_cnt + 16'd1;
        end
      end
    end else begin
      in_resp = 1'b0;
    end
  end

  // Issue one order, record the expected result, wait for its handshake.
  task automatic run_order(input logic [9:0] cid, input logic sl, input logic [15:0] qty,
                           input logic [15:0] lim, input int hold);
    exp_t e;
    int   n;
    int   held_cyc;
    logic done;
    e.cid = cid;
    if (hang) begin
      e.acc = 1'b0; e.rsn = 2'b10;
    end else if (sl) begin
      model_max[cid] = int'(lim);
      e.acc = 1'b1; e.rsn = 2'b00;
    end else if (model_acc[cid] + int'(qty) <= model_max[cid]) begin
      model_acc[cid] += int'(qty);
      e.acc = 1'b1; e.rsn = 2'b00;
    end else begin
      e.acc = 1'b0; e.rsn = 2'b01;
    end
    exp_q.push_back(e);
    cur_cid         = cid;
    order_client_id = cid;
    order_set_limit = sl;
    order_qty       = qty;
    order_limit     = lim;
    order_valid     = 1'b1;
    n = 0;
    while (!order_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("order_handshake_timeout", 66'd0, 66'd1);
    @(posedge clk); #1;
    order_valid = 1'b0;
    n = 0; held_cyc = 0; done = 1'b0;
    while (!done) begin
      if (result_ready) begin
        result_ready = 1'b0;
        done = 1'b1;
      end else if (result_valid) begin
        if (held_cyc < hold) held_cyc++;
        else result_ready = ($urandom_range(0, 2) != 0);
      end
      if (!done) begin
        n++;
        if (n > 400) begin
          check("result_wait_timeout", 66'd0, 66'd1);
          done = 1'b1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  initial begin
    int   n;
    int   v0;
    int   w0;
    int   r;
    logic saw_rv;
    logic [15:0] q;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0; model_max[i] = 0; model_acc[i] = 0;
    end
    rst = 1'b1;
    order_valid = 1'b0; order_client_id = '0; order_qty = '0;
    order_set_limit = 1'b0; order_limit = '0; result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_order_ready", {65'b0, order_ready}, 66'd1);
    check("rst_cpu_valid_rw", {64'b0, cpu_req.valid, cpu_req.rw}, 66'd0);
    check("rst_result", {62'b0, result_valid, result_accept, result_reason}, 66'd0);
    check("rst_counts", {34'b0, accept_count, reject_count}, 66'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed client 5 sequence
    stub_lat = 1;
    run_order(10'd5, 1'b1, 16'h0000, 16'h0100, 0);
    check("word_after_limit", {34'b0, mem[5]}, {34'b0, 32'h0100_0000});
    run_order(10'd5, 1'b0, 16'h0080, 16'h0000, 0);
    check("word_after_qty1", {34'b0, mem[5]}, {34'b0, 32'h0100_0080});
    run_order(10'd5, 1'b0, 16'h0080, 16'h0000, 0);
    check("word_at_limit", {34'b0, mem[5]}, {34'b0, 32'h0100_0100});
    w0 = wr_cnt;
    run_order(10'd5, 1'b0, 16'h0001, 16'h0000, 0);
    check("reject_no_write", 66'(wr_cnt), 66'(w0));
    check("word_after_reject", {34'b0, mem[5]}, {34'b0, 32'h0100_0100});
    check("reject_count_one", {50'b0, reject_count}, 66'd1);

    // Cache never ready: timeout after 64 waiting cycles
    hang = 1'b1;
    v0 = vcount;
    run_order(10'd3, 1'b0, 16'h0001, 16'h0000, 0);
    check("timeout_valid_cycles", 66'(vcount - v0), 66'd64);
    hang = 1'b0;

    // Result held off for 10 cycles; qty 0 accept writes nothing
    w0 = wr_cnt;
    run_order(10'd6, 1'b0, 16'h0000, 16'h0000, 10);
    check("qty0_no_write", 66'(wr_cnt), 66'(w0));
    check("hold_accept_count", {50'b0, accept_count}, {50'b0, exp_acc_cnt});

    // Random orders over a few clients
    for (int i = 0; i < 150; i++) begin
      stub_lat = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      if (r == 0)      q = 16'h0000;
      else if (r == 1) q = 16'hFFF0 + 16'($urandom_range(0, 15));
      else             q = 16'($urandom_range(0, 'h180));
      run_order(10'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), q,
                16'($urandom_range(0, 'h600)), $urandom_range(0, 3));
    end

    // Reset during WR_REQ aborts the transaction with no result
    hang_wr = 1'b1; stub_lat = 0; cur_cid = 10'd9;
    order_client_id = 10'd9; order_set_limit = 1'b1;
    order_qty = 16'h0; order_limit = 16'h0010; order_valid = 1'b1;
    @(posedge clk); #1;
    order_valid = 1'b0;
    n = 0;
    while (!(cpu_req.valid && cpu_req.rw) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_wr_req", {65'b0, (n < 50)}, 66'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_cpu_valid", {65'b0, cpu_req.valid}, 66'd0);
    check("rst_mid_order_ready", {65'b0, order_ready}, 66'd1);
    check("rst_mid_result_valid", {65'b0, result_valid}, 66'd0);
    @(posedge clk); #1;
    rst = 1'b0; hang_wr = 1'b0;
    saw_rv = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      saw_rv = saw_rv | result_valid;
    end
    check("rst_mid_no_result", {65'b0, saw_rv}, 66'd0);
    check("rst_mid_word_kept", {34'b0, mem[9]},
          {34'b0, model_max[9][15:0], model_acc[9][15:0]});
    run_order(10'd9, 1'b0, 16'h0000, 16'h0000, 0);

    check("scoreboard_empty", 66'(exp_q.size()), 66'd0);
    for (int i = 0; i < 10; i++) begin
      check("final_word", {34'b0, mem[i]}, {34'b0, model_max[i][15:0], model_acc[i][15:0]});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
